chase_servo: RTL and testbench
==============================

# chase_servo

Closed-loop pan-servo driver for the laser-chasing pipeline. It sits directly downstream of the laser-detection stage and consumes that stage's per-frame two-bit left/right detection result. It debounces the detections over several frames, commits a tracking direction, and slews a hobby-servo pulse width toward the dot. If the dot is lost for long enough, it sweeps the servo to search for it.

## Interface
Parameters:
- `PERIOD_CYCLES`, default 1966080: servo PWM period in `clk_in` cycles (20 ms at 98.304 MHz).
- `MIN_WIDTH`, default 98304: minimum pulse width in cycles (1 ms).
- `MAX_WIDTH`, default 196608: maximum pulse width in cycles (2 ms).
- `STEP`, default 983: pulse-width change per PWM period while moving.
- `DEBOUNCE`, default 3: consecutive identical samples needed to commit a direction.
- `LOST_SAMPLES`, default 8: consecutive "none" samples needed to enter SEARCH.
- Derived: `W = $clog2(PERIOD_CYCLES+1)`.

Ports:
- `clk_in`  input  1: system clock; the only clock.
- `rst_in`  input  1: reset; synchronous, active-high.
- `detected_in`  input  2: detection result; bit 1 = left half over threshold, bit 0 = right half.
- `sample_in`  input  1: one-cycle strobe; `detected_in` is sampled only on this cycle (at most once per frame).
- `servo_pwm_out`  output  1: registered servo PWM.
- `position_out`  output  W: current commanded pulse width in cycles.
- `state_out`  output  2: 0 HOLD, 1 LEFT, 2 RIGHT, 3 SEARCH.

## Operation
- **Classification on `sample_in`.** 2'b10 → L, 2'b01 → R, 2'b11 → C (dot centred), 2'b00 → N (none).
- **Debounce.** Holds a candidate class `cand` and a count `cnt` that saturates at `DEBOUNCE`.
  - Sample equals `cand`: increment `cnt`, saturating.
  - Otherwise: set `cand` to the new class and `cnt` to 1.
  - Commit happens on the sample where `cnt` becomes exactly `DEBOUNCE`, and only for L/R/C.
  - Commit mapping: L → LEFT, R → RIGHT, C → HOLD. A commit from any state, including SEARCH, takes effect.
- **Loss detection.** Uses a separate counter `lost`.
  - An N sample increments `lost`, saturating at `LOST_SAMPLES`.
  - Any non-N sample clears `lost` to 0.
  - When `lost` becomes `LOST_SAMPLES`, the state goes to SEARCH.
  - Before that, N samples leave the state unchanged.
- **PWM counter.** `pcnt` counts 0..`PERIOD_CYCLES`-1 and wraps to 0.
  - `act` latches `position_out` when `pcnt`==0.
  - `servo_pwm_out <= (pcnt < act)`.
- **Position update.** Happens once per period, on the cycle `pcnt`==`PERIOD_CYCLES`-1, using the state value registered before that edge.
  - LEFT: `+STEP`, clamped to `MAX_WIDTH`.
  - RIGHT: `-STEP`, clamped to `MIN_WIDTH`.
  - HOLD: unchanged.
  - SEARCH: move `STEP` in direction `sweep_up`. On reaching or clamping at `MAX_WIDTH`, clear `sweep_up`; on reaching or clamping at `MIN_WIDTH`, set it. `sweep_up` persists across SEARCH entries.
- **Arithmetic.** Compute in W+1 bits before clamping; no wrap-around is permitted.

## Timing
- **Reset values.**
  - state HOLD (`state_out`=0).
  - `position_out` = (`MIN_WIDTH`+`MAX_WIDTH`)/2, floor.
  - `pcnt`=0, `act`=0, `servo_pwm_out`=0.
  - `cand`=N, `cnt`=0, `lost`=0, `sweep_up`=1.
- **Output latency.**
  - `state_out` changes 1 cycle after the committing `sample_in`.
  - `position_out` changes 1 cycle after `pcnt`==`PERIOD_CYCLES`-1.
  - `servo_pwm_out` is registered and lags `pcnt` by 1 cycle.
  - A new width is visible on `servo_pwm_out` from the period that starts right after the update. Widths never change mid-period.
- **Simultaneous events.** If `sample_in` coincides with the period-end update, the update uses the old state; the new state affects the next period.
- **Reset mid-operation.** Everything returns to reset values on the next edge. `servo_pwm_out` is 0 the cycle after reset deasserts, then high from the following cycle for `act` cycles. After reset `act` is 0 until the first `pcnt`==0 latch.
- **`sample_in` while `rst_in` is high** is ignored.

## Test plan
Bench parameters: `PERIOD_CYCLES`=100, `MIN_WIDTH`=10, `MAX_WIDTH`=30, `STEP`=5, `DEBOUNCE`=3, `LOST_SAMPLES`=4. Reset position is 20.

1. **Reset/PWM.** Release reset and run 300 cycles with no samples → `state_out`=0, `position_out`=20, and `servo_pwm_out` high for exactly 20 consecutive cycles per 100-cycle period.
2. **Debounce.** Samples 10,10,01,10,10,10 → `state_out` stays 0 through the fifth sample and becomes 1 one cycle after the sixth. No earlier change occurs.
3. **Slew/clamp.** Commit LEFT and run 4 periods → `position_out` steps 25, 30, 30, 30. Then commit RIGHT and run 5 periods → 25, 20, 15, 10, 10.
4. **Loss/search.** From HOLD send 00 ×4 → `state_out`=3 after the fourth sample. `position_out` sweeps 25, 30, 25, 20, 15, 10, 15 over successive periods. Then 11 ×3 → `state_out`=0 and position freezes.
5. **Collision.** Assert `sample_in` with committing 01 exactly at `pcnt`=99 while in LEFT at 20 → `position_out`=25 this period and 20 at the next period end.
6. **Mid-run reset.** Pulse `rst_in` for 1 cycle in SEARCH at position 10 → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/chase_servo.sv
// Pan-servo driver: debounces per-frame left/right detections, commits a tracking direction,
// and slews a hobby-servo pulse width toward the dot, sweeping to search when it is lost.
module chase_servo #(
    parameter int unsigned PERIOD_CYCLES = 1966080,
    parameter int unsigned MIN_WIDTH     = 98304,
    parameter int unsigned MAX_WIDTH     = 196608,
    parameter int unsigned STEP          = 983,
    parameter int unsigned DEBOUNCE      = 3,
    parameter int unsigned LOST_SAMPLES  = 8,
    localparam int unsigned W            = $clog2(PERIOD_CYCLES + 1)
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [1:0]   detected_in,
    input  logic         sample_in,
    output logic         servo_pwm_out,
    output logic [W-1:0] position_out,
    output logic [1:0]   state_out
);

    localparam int unsigned W1 = W + 1;
    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam int unsigned LW = $clog2(LOST_SAMPLES + 1);

    localparam logic [W-1:0]  PEND   = W'(PERIOD_CYCLES - 1);
    localparam logic [W-1:0]  MIN_P  = W'(MIN_WIDTH);
    localparam logic [W-1:0]  MAX_P  = W'(MAX_WIDTH);
    localparam logic [W-1:0]  RST_P  = W'((MIN_WIDTH + MAX_WIDTH) / 2);
    localparam logic [W:0]    MIN_X  = W1'(MIN_WIDTH);
    localparam logic [W:0]    MAX_X  = W1'(MAX_WIDTH);
    localparam logic [W:0]    STEP_X = W1'(STEP);
    localparam logic [CW-1:0] DB     = CW'(DEBOUNCE);
    localparam logic [LW-1:0] LS     = LW'(LOST_SAMPLES);

    localparam logic [1:0] CLS_N = 2'b00;
    localparam logic [1:0] CLS_R = 2'b01;
    localparam logic [1:0] CLS_L = 2'b10;
    localparam logic [1:0] CLS_C = 2'b11;

    typedef enum logic [1:0] {
        StHold   = 2'd0,
        StLeft   = 2'd1,
        StRight  = 2'd2,
        StSearch = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] lost_q, lost_d;
    logic [W-1:0]  pos_q, pos_d;
    logic [W-1:0]  pcnt_q, pcnt_d;
    logic [W-1:0]  act_q, act_d;
    logic          pwm_q, pwm_d;
    logic          sweep_q, sweep_d;

    logic [W:0]    pos_x, up_sum, dn_diff;
    logic [W-1:0]  up_pos, dn_pos;
    logic          commit;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        lost_d  = lost_q;
        pos_d   = pos_q;
        sweep_d = sweep_q;
        commit  = 1'b0;

        pcnt_d = (pcnt_q == PEND) ? '0 : pcnt_q + 1'b1;
        act_d  = (pcnt_q == '0) ? pos_q : act_q;
        pwm_d  = (pcnt_q < act_q);

        // Extended-width slew candidates; clamping happens before truncation.
        pos_x   = {1'b0, pos_q};
        up_sum  = pos_x + STEP_X;
        dn_diff = pos_x - STEP_X;
        up_pos  = (up_sum >= MAX_X) ? MAX_P : up_sum[W-1:0];
        dn_pos  = (pos_x <= MIN_X + STEP_X) ? MIN_P : dn_diff[W-1:0];

        if (sample_in) begin
            if (detected_in == cand_q) begin
                if (cnt_q != DB) cnt_d = cnt_q + 1'b1;
            end else begin
                cand_d = detected_in;
                cnt_d  = CW'(1);
            end
            // Only the transition into DB commits; a saturated run of the same class does not.
            commit = (cnt_d == DB) && ((cnt_q != DB) || (detected_in != cand_q));

            if (detected_in == CLS_N) begin
                if (lost_q != LS) lost_d = lost_q + 1'b1;
                if ((lost_d == LS) && (lost_q != LS)) state_d = StSearch;
            end else begin
                lost_d = '0;
                if (commit) begin
                    unique case (detected_in)
                        CLS_L:   state_d = StLeft;
                        CLS_R:   state_d = StRight;
                        CLS_C:   state_d = StHold;
                        default: state_d = state_q;
                    endcase
                end
            end
        end

        if (pcnt_q == PEND) begin
            unique case (state_q)
                StLeft:  pos_d = up_pos;
                StRight: pos_d = dn_pos;
                StSearch: begin
                    if (sweep_q) begin
                        pos_d = up_pos;
                        if (up_pos == MAX_P) sweep_d = 1'b0;
                    end else begin
                        pos_d = dn_pos;
                        if (dn_pos == MIN_P) sweep_d = 1'b1;
                    end
                end
                default: pos_d = pos_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StHold;
            cand_q  <= CLS_N;
            cnt_q   <= '0;
            lost_q  <= '0;
            pos_q   <= RST_P;
            pcnt_q  <= '0;
            act_q   <= '0;
            pwm_q   <= 1'b0;
            sweep_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            lost_q  <= lost_d;
            pos_q   <= pos_d;
            pcnt_q  <= pcnt_d;
            act_q   <= act_d;
            pwm_q   <= pwm_d;
            sweep_q <= sweep_d;
        end
    end

    assign servo_pwm_out = pwm_q;
    assign position_out  = pos_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_chase_servo.sv
// Directed bench for chase_servo with a 100-cycle period, widths 10..30 and step 5.
module tb_chase_servo;

    localparam int unsigned W = 7;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic [1:0]   detected_in = 2'b00;
    logic         sample_in = 1'b0;
    logic         servo_pwm_out;
    logic [W-1:0] position_out;
    logic [1:0]   state_out;

    int errors = 0;
    int checks = 0;
    int tb_p   = 0;

    chase_servo #(
        .PERIOD_CYCLES(100),
        .MIN_WIDTH    (10),
        .MAX_WIDTH    (30),
        .STEP         (5),
        .DEBOUNCE     (3),
        .LOST_SAMPLES (4)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .detected_in  (detected_in),
        .sample_in    (sample_in),
        .servo_pwm_out(servo_pwm_out),
        .position_out (position_out),
        .state_out    (state_out)
    );

    always #5 clk_in = ~clk_in;

    // Bench-side period phase, used only to schedule stimulus.
    always @(posedge clk_in) begin
        if (rst_in) tb_p <= 0;
        else        tb_p <= (tb_p == 99) ? 0 : tb_p + 1;
    end

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        sample_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic send(input logic [1:0] d);
        detected_in = d;
        sample_in = 1'b1;
        @(negedge clk_in);
        sample_in = 1'b0;
        @(negedge clk_in);
    endtask

    // Returns at the negedge just after the period-end update edge.
    task automatic wait_update();
        int n = 0;
        while (tb_p != 99 && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 300) begin
            errors++;
            $display("FAIL wait_update timeout: tb_p=%0d", tb_p);
        end
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        int runs[$];
        int run = 0;
        logic prev = 1'b0;
        do_reset();
        checks++;
        if (servo_pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_pwm: got %0b want 0", servo_pwm_out);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_in);
            if (servo_pwm_out === 1'b1) run++;
            else if (prev) begin
                runs.push_back(run);
                run = 0;
            end
            prev = servo_pwm_out;
        end
        checks++;
        if (state_out !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d want 0", state_out);
        end
        checks++;
        if (position_out !== 7'd20) begin
            errors++;
            $display("FAIL reset_position: got %0d want 20", position_out);
        end
        checks++;
        if (runs.size() != 3) begin
            errors++;
            $display("FAIL pwm_pulse_count: got %0d want 3", runs.size());
        end else begin
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (runs[k] != 20) begin
                    errors++;
                    $display("FAIL pwm_width[%0d]: got %0d want 20", k, runs[k]);
                end
            end
        end
    endtask

    task automatic test_debounce();
        logic [1:0] seq [6] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10};
        logic [1:0] exp [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(seq[i]);
            checks++;
            if (state_out !== exp[i]) begin
                errors++;
                $display("FAIL debounce[%0d]: state got %0d want %0d", i, state_out, exp[i]);
            end
        end
    endtask

    task automatic test_slew_clamp();
        logic [W-1:0] up [4] = '{7'd25, 7'd30, 7'd30, 7'd30};
        logic [W-1:0] dn [5] = '{7'd25, 7'd20, 7'd15, 7'd10, 7'd10};
        do_reset();
        repeat (3) send(2'b10);
        for (int i = 0; i < 4; i++) begin
            wait_update();
            checks++;
            if (position_out !== up[i]) begin
                errors++;
                $display("FAIL slew_left[%0d]: got %0d want %0d", i, position_out, up[i]);
            end
        end
        repeat (3) send(2'b01);
        checks++;
        if (state_out !== 2'd2) begin
            errors++;
            $display("FAIL commit_right: state got %0d want 2", state_out);
        end
        for (int i = 0; i < 5; i++) begin
            wait_update();
            checks++;
            if (position_out !== dn[i]) begin
                errors++;
                $display("FAIL slew_right[%0d]: got %0d want %0d", i, position_out, dn[i]);
            end
        end
    endtask

    task automatic test_search();
        logic [W-1:0] sw [7] = '{7'd25, 7'd30, 7'd25, 7'd20, 7'd15, 7'd10, 7'd15};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(2'b00);
            checks++;
            if (state_out !== ((i == 3) ? 2'd3 : 2'd0)) begin
                errors++;
                $display("FAIL lost[%0d]: state got %0d want %0d", i, state_out,
                         (i == 3) ? 3 : 0);
            end
        end
        for (int i = 0; i < 7; i++) begin
            wait_update();
            checks++;
            if (position_out !== sw[i]) begin
                errors++;
                $display("FAIL sweep[%0d]: got %0d want %0d", i, position_out, sw[i]);
            end
        end
        repeat (3) send(2'b11);
        checks++;
        if (state_out !== 2'd0) begin
            errors++;
            $display("FAIL search_exit: state got %0d want 0", state_out);
        end
        wait_update();
        checks++;
        if (position_out !== 7'd15) begin
            errors++;
            $display("FAIL hold_freeze: got %0d want 15", position_out);
        end
    endtask

    task automatic test_collision();
        int n = 0;
        do_reset();
        repeat (3) send(2'b10);
        repeat (2) send(2'b01);
        checks++;
        if (state_out !== 2'd1) begin
            errors++;
            $display("FAIL collide_pre: state got %0d want 1", state_out);
        end
        while (tb_p != 99 && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        detected_in = 2'b01;
        sample_in = 1'b1;
        @(negedge clk_in);
        sample_in = 1'b0;
        checks++;
        if (position_out !== 7'd25 || state_out !== 2'd2) begin
            errors++;
            $display("FAIL collide_edge: pos %0d state %0d want pos 25 state 2",
                     position_out, state_out);
        end
        wait_update();
        checks++;
        if (position_out !== 7'd20) begin
            errors++;
            $display("FAIL collide_next: got %0d want 20", position_out);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        repeat (4) send(2'b00);
        repeat (6) wait_update();
        checks++;
        if (position_out !== 7'd10 || state_out !== 2'd3) begin
            errors++;
            $display("FAIL pre_reset: pos %0d state %0d want pos 10 state 3",
                     position_out, state_out);
        end
        repeat (30) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        checks++;
        if (state_out !== 2'd0 || position_out !== 7'd20 || servo_pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: state %0d pos %0d pwm %0b want 0 20 0",
                     state_out, position_out, servo_pwm_out);
        end
        @(negedge clk_in);
        checks++;
        if (servo_pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_pwm0: got %0b want 0", servo_pwm_out);
        end
        @(negedge clk_in);
        checks++;
        if (servo_pwm_out !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_pwm1: got %0b want 1", servo_pwm_out);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_slew_clamp();
        test_search();
        test_collision();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
